// File: rtl/moore_seq_detector.sv
// Moore serial pattern detector: runtime-loadable PAT_W-bit pattern, overlap/non-overlap modes,
// saturating match counter. Optional sticky irq output is enabled by defining MOORE_SEQ_IRQ_EN.
module moore_seq_detector #(
  parameter int unsigned        PAT_W   = 4,
  parameter logic [PAT_W-1:0]   PAT_RST = 4'b1101,
  parameter int unsigned        CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             i,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             overlap,
  input  logic             cnt_clr,
`ifdef MOORE_SEQ_IRQ_EN
  input  logic             irq_clr,
  output logic             irq,
`endif
  output logic             o,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int unsigned      FW        = $clog2(PAT_W + 1);
  localparam logic [FW-1:0]    FILL_FULL = FW'(PAT_W);

  logic [PAT_W-1:0] pattern_q;
  logic [PAT_W-1:0] hist_q, hist_d;
  logic [FW-1:0]    fill_q, fill_d, fill_base;
  logic             match_q, match_d;
  logic [CNT_W-1:0] cnt_q;
  logic             hit;

  always_comb begin
    // Non-overlap mode: the bit following a match starts a fresh window.
    fill_base = (match_q && !overlap) ? '0 : fill_q;
    fill_d    = (fill_base == FILL_FULL) ? FILL_FULL : fill_base + 1'b1;
    hist_d    = {hist_q[PAT_W-2:0], i};
    match_d   = (fill_d == FILL_FULL) && (hist_d == pattern_q);
    hit       = en && !pat_load && match_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pattern_q <= PAT_RST;
      hist_q    <= '0;
      fill_q    <= '0;
      match_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      if (pat_load) begin
        pattern_q <= pat_in;
        hist_q    <= '0;
        fill_q    <= '0;
        match_q   <= 1'b0;
      end else if (en) begin
        hist_q    <= hist_d;
        fill_q    <= fill_d;
        match_q   <= match_d;
      end

      if (cnt_clr) begin
        cnt_q <= hit ? CNT_W'(1) : '0;
      end else if (hit && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

`ifdef MOORE_SEQ_IRQ_EN
  logic irq_q;

  // Set has priority over clear so a coincident match is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_q <= 1'b0;
    end else if (hit) begin
      irq_q <= 1'b1;
    end else if (irq_clr) begin
      irq_q <= 1'b0;
    end
  end

  assign irq = irq_q;
`endif

  assign o         = match_q;
  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_moore_seq_detector.sv
// Randomized + directed bench for moore_seq_detector; reference model keeps a queue of the
// bits received since the last window restart and compares its tail to the pattern.
module tb_moore_seq_detector;

  localparam int PAT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b0, i = 1'b0, pat_load = 1'b0, overlap = 1'b1, cnt_clr = 1'b0;
  logic [PAT_W-1:0] pat_in = '0;
  logic             o, o2;
  logic [7:0]       match_cnt;
  logic [1:0]       cnt2;
`ifdef MOORE_SEQ_IRQ_EN
  logic irq_clr = 1'b0;
  logic irq, irq2;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [PAT_W-1:0] m_pat;
  bit               m_q[$];
  logic             m_o;
  int               m_cnt, m_cnt2;
  logic             m_irq;

  moore_seq_detector #(.PAT_W(PAT_W), .PAT_RST(4'b1101), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .en(en), .i(i), .pat_load(pat_load), .pat_in(pat_in),
    .overlap(overlap), .cnt_clr(cnt_clr),
`ifdef MOORE_SEQ_IRQ_EN
    .irq_clr(irq_clr), .irq(irq),
`endif
    .o(o), .match_cnt(match_cnt)
  );

  moore_seq_detector #(.PAT_W(PAT_W), .PAT_RST(4'b1101), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .en(en), .i(i), .pat_load(pat_load), .pat_in(pat_in),
    .overlap(overlap), .cnt_clr(cnt_clr),
`ifdef MOORE_SEQ_IRQ_EN
    .irq_clr(irq_clr), .irq(irq2),
`endif
    .o(o2), .match_cnt(cnt2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("o", 32'(o), 32'(m_o));
    check("o2", 32'(o2), 32'(m_o));
    check("cnt", 32'(match_cnt), 32'(m_cnt));
    check("cnt2", 32'(cnt2), 32'(m_cnt2));
`ifdef MOORE_SEQ_IRQ_EN
    check("irq", 32'(irq), 32'(m_irq));
    check("irq2", 32'(irq2), 32'(m_irq));
`endif
  endtask

  task automatic model_reset();
    m_pat  = 4'b1101;
    m_q.delete();
    m_o    = 1'b0;
    m_cnt  = 0;
    m_cnt2 = 0;
    m_irq  = 1'b0;
  endtask

  // Asynchronous reset pulse between clock edges; outputs must clear immediately.
  task automatic do_reset();
    rst = 1'b1;
    #2;
    model_reset();
    check("rst_o", 32'(o), 32'd0);
    check("rst_cnt", 32'(match_cnt), 32'd0);
    rst = 1'b0;
  endtask

  task automatic tick();
    bit hit;
    bit match;
    int n;
    @(posedge clk);
    hit = 1'b0;
    if (pat_load) begin
      m_pat = pat_in;
      m_q.delete();
      m_o = 1'b0;
    end else if (en) begin
      if (m_o && !overlap) m_q.delete();
      m_q.push_back(i);
      if (m_q.size() > PAT_W) void'(m_q.pop_front());
      n = m_q.size();
      match = (n == PAT_W);
      for (int k = 0; k < PAT_W && match; k++)
        if (m_q[k] != m_pat[PAT_W-1-k]) match = 1'b0;
      m_o = match;
      hit = match;
    end
    if (cnt_clr) begin
      m_cnt  = hit ? 1 : 0;
      m_cnt2 = hit ? 1 : 0;
    end else if (hit) begin
      if (m_cnt < 255) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end
`ifdef MOORE_SEQ_IRQ_EN
    if (hit) m_irq = 1'b1;
    else if (irq_clr) m_irq = 1'b0;
`endif
    #1;
    check_all();
    $display("t=%0t en=%b i=%b ld=%b pat=%b ov=%b clr=%b o=%b cnt=%0d cnt2=%0d",
             $time, en, i, pat_load, pat_in, overlap, cnt_clr, o, match_cnt, cnt2);
  endtask

  task automatic send(input logic b);
    en = 1'b1; i = b; pat_load = 1'b0; cnt_clr = 1'b0;
    tick();
  endtask

  task automatic send_seq(input logic [15:0] bits, input int len);
    for (int k = len - 1; k >= 0; k--) send(bits[k]);
  endtask

  initial begin
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // Basic detection with fixed expectations
    overlap = 1'b1;
    send(1'b1); check("tp1_e1", 32'(o), 32'd0);
    send(1'b1); check("tp1_e2", 32'(o), 32'd0);
    send(1'b0); check("tp1_e3", 32'(o), 32'd0);
    send(1'b1); check("tp1_e4", 32'(o), 32'd1);
    check("tp1_cnt", 32'(match_cnt), 32'd1);
    send(1'b0); check("tp1_e5", 32'(o), 32'd0);

    // Overlapping stream
    do_reset(); overlap = 1'b1;
    send_seq(16'b1101101, 7);
    check("ov_o", 32'(o), 32'd1);
    check("ov_cnt", 32'(match_cnt), 32'd2);

    // Non-overlapping stream
    do_reset(); overlap = 1'b0;
    send_seq(16'b1101101, 7);
    check("nov_o", 32'(o), 32'd0);
    check("nov_cnt", 32'(match_cnt), 32'd1);

    // Hold cycles ignored
    do_reset(); overlap = 1'b1;
    send_seq(16'b11, 2);
    for (int k = 0; k < 3; k++) begin en = 1'b0; i = k[0]; tick(); end
    send_seq(16'b01, 2);
    check("hold_o", 32'(o), 32'd1);
    en = 1'b0; i = 1'b0; tick();
    check("hold_keep", 32'(o), 32'd1);

    // Pattern load discards history, then reset restores default pattern
    do_reset();
    send_seq(16'b01, 2);
    pat_load = 1'b1; pat_in = 4'b0110; en = 1'b1; i = 1'b1; tick();
    send_seq(16'b0110, 4);
    check("load_o", 32'(o), 32'd1);
    do_reset();
    send_seq(16'b1101, 4);
    check("rst_pat_o", 32'(o), 32'd1);

    // Counter saturation on the 2-bit instance, then clear concurrent with a match
    do_reset(); overlap = 1'b1;
    pat_load = 1'b1; pat_in = 4'b1111; en = 1'b1; tick();
    send_seq(16'hFF, 8);
    check("sat_cnt2", 32'(cnt2), 32'd3);
    en = 1'b1; i = 1'b1; cnt_clr = 1'b1; tick();
    check("clr_cnt2", 32'(cnt2), 32'd1);
    cnt_clr = 1'b0;

`ifdef MOORE_SEQ_IRQ_EN
    irq_clr = 1'b1; en = 1'b1; i = 1'b1; tick();
    check("irq_setwins", 32'(irq), 32'd1);
    en = 1'b0; tick();
    check("irq_clr", 32'(irq), 32'd0);
    irq_clr = 1'b0;
`endif

    // Randomized traffic
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      en       = ($urandom_range(0, 9) < 8);
      i        = $urandom_range(0, 1) != 0;
      pat_load = ($urandom_range(0, 49) == 0);
      pat_in   = ($urandom_range(0, 1) != 0) ? 4'b1111 : PAT_W'($urandom);
      if ($urandom_range(0, 19) == 0) overlap = ~overlap;
      cnt_clr  = ($urandom_range(0, 39) == 0);
`ifdef MOORE_SEQ_IRQ_EN
      irq_clr  = ($urandom_range(0, 19) == 0);
`endif
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
